// File: rtl/rvvi_flow_control_pkg.sv
// Types and widths shared by the RVVI transmit flow controller and its gap timer.
package rvvi_flow_control_pkg;
  localparam int GAP_TIMER_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, SEND, GAP} flowState_t;
endpackage

// File: rtl/rvvi_gap_timer.sv
// Loadable down-counter that times the inter-packet gap; expire marks the last gap cycle.
module rvvi_gap_timer
  import rvvi_flow_control_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       en,
  input  logic [GAP_TIMER_WIDTH-1:0] loadValue,
  output logic                       expire
);

  logic [GAP_TIMER_WIDTH-1:0] count;

  // Load wins over decrement; the counter parks at zero once drained.
  always_ff @(posedge clk) begin
    if (reset)                     count <= '0;
    else if (load)                 count <= loadValue;
    else if (en && (count != '0))  count <= count - 1'b1;
  end

  assign expire = (count == GAP_TIMER_WIDTH'(1));

endmodule

// File: rtl/rvvi_flow_control.sv
// Transmit-side flow control for the RVVI trace link: grants frames, spaces them by the
// host-requested gap, and bounds unacknowledged frames to WINDOW with a timeout resync.
module rvvi_flow_control
  import rvvi_flow_control_pkg::*;
#(
  parameter int                         FRAME_COUNT_WIDTH = 64,
  parameter int                         WINDOW            = 16,
  parameter int                         ACK_TIMEOUT       = 1 << 24,
  parameter logic [GAP_TIMER_WIDTH-1:0] DEFAULT_DELAY     = 32'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          FrameReq,
  output logic                          FrameGrant,
  input  logic                          FrameDone,
  input  logic                          AckValid,
  input  logic [FRAME_COUNT_WIDTH-1:0]  AckFrameCount,
  input  logic [GAP_TIMER_WIDTH-1:0]    AckDelay,
  output logic [FRAME_COUNT_WIDTH-1:0]  TxFrameCount,
  output logic [$clog2(WINDOW+1)-1:0]   InFlight,
  output logic [GAP_TIMER_WIDTH-1:0]    CurrDelay,
  output logic                          Stall,
  output logic                          AckTimeout
);

  localparam int IW = $clog2(WINDOW + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IW-1:0] WINDOW_L = IW'(WINDOW);

  flowState_t                   state, nextState;
  logic [FRAME_COUNT_WIDTH-1:0] lastAck;
  logic [FRAME_COUNT_WIDTH-1:0] inFlightWide;
  logic [FRAME_COUNT_WIDTH-1:0] ackDist;
  logic [TW-1:0]                timeoutCount;
  logic                         frameIssue, ackAccept, timeoutHit;
  logic                         gapLoad, gapExpire;

  // Modular differences make both the in-flight count and the ack check wrap-safe.
  assign inFlightWide = TxFrameCount - lastAck;
  assign InFlight     = IW'(inFlightWide);
  assign ackDist      = TxFrameCount - AckFrameCount;
  assign ackAccept    = AckValid && (ackDist <= inFlightWide);

  assign FrameGrant = (state == IDLE) && (InFlight < WINDOW_L);
  assign Stall      = (InFlight == WINDOW_L);
  assign frameIssue = FrameReq && FrameGrant;
  assign timeoutHit = (InFlight != '0) && !ackAccept && (timeoutCount == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    gapLoad   = 1'b0;
    case (state)
      IDLE: if (frameIssue) nextState = SEND;
      SEND: if (FrameDone) begin
        if (CurrDelay == '0) nextState = IDLE;
        else begin
          nextState = GAP;
          gapLoad   = 1'b1;
        end
      end
      GAP:  if (gapExpire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  rvvi_gap_timer gapTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (gapLoad),
    .en        (state == GAP),
    .loadValue (CurrDelay),
    .expire    (gapExpire)
  );

  // An accepted ack and a grant in the same cycle both land; acceptance uses the old count.
  always_ff @(posedge clk) begin
    if (reset) begin
      TxFrameCount <= '0;
      lastAck      <= '0;
      CurrDelay    <= DEFAULT_DELAY;
      timeoutCount <= '0;
      AckTimeout   <= 1'b0;
    end else begin
      if (frameIssue) TxFrameCount <= TxFrameCount + 1'b1;
      if (ackAccept) begin
        lastAck   <= AckFrameCount;
        CurrDelay <= AckDelay;
      end else if (timeoutHit) begin
        lastAck    <= TxFrameCount;
        AckTimeout <= 1'b1;
      end
      if (ackAccept || timeoutHit || (InFlight == '0)) timeoutCount <= '0;
      else                                            timeoutCount <= timeoutCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_rvvi_flow_control.sv
// Scenario bench for rvvi_flow_control: a 64-bit instance for flow/ack/timeout behaviour
// and a 4-bit instance to exercise sequence-counter wrap-around.
module tb_rvvi_flow_control;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] expTx, expLast, got;

  // Main instance: 64-bit counters, window 16, short timeout.
  logic        reset, FrameReq, FrameGrant, FrameDone, AckValid, Stall, AckTimeout;
  logic [63:0] AckFrameCount, TxFrameCount;
  logic [31:0] AckDelay, CurrDelay;
  logic [4:0]  InFlight;

  rvvi_flow_control #(.FRAME_COUNT_WIDTH(64), .WINDOW(16), .ACK_TIMEOUT(100), .DEFAULT_DELAY(32'd0)) dut (
    .clk(clk), .reset(reset), .FrameReq(FrameReq), .FrameGrant(FrameGrant), .FrameDone(FrameDone),
    .AckValid(AckValid), .AckFrameCount(AckFrameCount), .AckDelay(AckDelay),
    .TxFrameCount(TxFrameCount), .InFlight(InFlight), .CurrDelay(CurrDelay),
    .Stall(Stall), .AckTimeout(AckTimeout)
  );

  // Small instance: 4-bit counters, window 4, so wrap is reachable in a few frames.
  logic        sReset, sFrameReq, sFrameGrant, sFrameDone, sAckValid, sStall, sAckTimeout;
  logic [3:0]  sAckFrameCount, sTxFrameCount;
  logic [31:0] sAckDelay, sCurrDelay;
  logic [2:0]  sInFlight;

  rvvi_flow_control #(.FRAME_COUNT_WIDTH(4), .WINDOW(4), .ACK_TIMEOUT(1000), .DEFAULT_DELAY(32'd0)) dutSmall (
    .clk(clk), .reset(sReset), .FrameReq(sFrameReq), .FrameGrant(sFrameGrant), .FrameDone(sFrameDone),
    .AckValid(sAckValid), .AckFrameCount(sAckFrameCount), .AckDelay(sAckDelay),
    .TxFrameCount(sTxFrameCount), .InFlight(sInFlight), .CurrDelay(sCurrDelay),
    .Stall(sStall), .AckTimeout(sAckTimeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset = 1'b1; FrameReq = 1'b0; FrameDone = 1'b0; AckValid = 1'b0;
    AckFrameCount = '0; AckDelay = '0;
    step(); step();
    reset = 1'b0;
    expTx = '0; expLast = '0;
    expQ.delete();
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if (TxFrameCount !== 64'd0 || InFlight !== 5'd0) begin
      errors++; $display("FAIL reset_counts tx=%0d inflight=%0d want 0/0", TxFrameCount, InFlight);
    end
    checks++;
    if (CurrDelay !== 32'd0 || Stall !== 1'b0 || AckTimeout !== 1'b0) begin
      errors++; $display("FAIL reset_flags delay=%0d stall=%b timeout=%b want 0/0/0", CurrDelay, Stall, AckTimeout);
    end
    checks++;
    if (FrameGrant !== 1'b1) begin
      errors++; $display("FAIL reset_grant got %b want 1", FrameGrant);
    end
  endtask

  task automatic test_fill_window();
    applyReset();
    FrameReq = 1'b1;
    for (int f = 1; f <= 16; f++) begin
      int waitc = 0;
      while (FrameGrant !== 1'b1 && waitc < 12) begin step(); waitc++; end
      checks++;
      if (waitc != 0) begin
        errors++; $display("FAIL fill_spacing frame %0d extra wait %0d want 0", f, waitc);
      end
      expTx = expTx + 1; expQ.push_back(expTx);
      step();
      got = expQ.pop_front();
      $display("frame tx=%0d inflight=%0d stall=%b", TxFrameCount, InFlight, Stall);
      checks++;
      if (TxFrameCount !== got || InFlight !== 5'(f) || Stall !== (f == 16)) begin
        errors++; $display("FAIL fill_frame tx=%0d inflight=%0d stall=%b want %0d/%0d/%b",
                           TxFrameCount, InFlight, Stall, got, f, (f == 16));
      end
      step(); step();
      FrameDone = 1'b1; step(); FrameDone = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (FrameGrant !== 1'b0 || Stall !== 1'b1 || TxFrameCount !== expTx) begin
        errors++; $display("FAIL full_hold grant=%b stall=%b tx=%0d want 0/1/%0d", FrameGrant, Stall, TxFrameCount, expTx);
      end
      step();
    end
  endtask

  task automatic test_ack_window();
    int idle = 0;
    FrameReq = 1'b0;
    AckValid = 1'b1; AckFrameCount = 64'd10; AckDelay = 32'd5;
    step();
    AckValid = 1'b0; expLast = 64'd10;
    checks++;
    if (InFlight !== 5'(expTx - expLast) || Stall !== 1'b0 || CurrDelay !== 32'd5 || FrameGrant !== 1'b1) begin
      errors++; $display("FAIL ack_release inflight=%0d stall=%b delay=%0d grant=%b want 6/0/5/1",
                         InFlight, Stall, CurrDelay, FrameGrant);
    end
    FrameReq = 1'b1; expTx = expTx + 1; expQ.push_back(expTx);
    step();
    FrameReq = 1'b0;
    got = expQ.pop_front();
    $display("frame tx=%0d inflight=%0d", TxFrameCount, InFlight);
    checks++;
    if (TxFrameCount !== got || InFlight !== 5'(expTx - expLast)) begin
      errors++; $display("FAIL ack_frame tx=%0d inflight=%0d want %0d/%0d", TxFrameCount, InFlight, got, expTx - expLast);
    end
    FrameDone = 1'b1; step(); FrameDone = 1'b0;
    while (FrameGrant !== 1'b1 && idle < 20) begin idle++; step(); end
    checks++;
    if (idle != 5) begin
      errors++; $display("FAIL gap_len idle=%0d want 5", idle);
    end
  endtask

  task automatic test_ack_reject();
    logic [63:0] ackVals[4];
    logic [31:0] delayVals[4];
    logic [63:0] lastVals[4];
    logic [31:0] currVals[4];
    // future, older-than-LastAck, equal to LastAck (boundary accept), fully caught up
    ackVals   = '{expTx + 1, expLast - 1, expLast, expTx};
    delayVals = '{32'd9, 32'd9, 32'd3, 32'd0};
    lastVals  = '{expLast, expLast, expLast, expTx};
    currVals  = '{32'd5, 32'd5, 32'd3, 32'd0};
    for (int i = 0; i < 4; i++) begin
      AckValid = 1'b1; AckFrameCount = ackVals[i]; AckDelay = delayVals[i];
      step();
      AckValid = 1'b0;
      $display("ack count=%0d inflight=%0d delay=%0d", ackVals[i], InFlight, CurrDelay);
      checks++;
      if (InFlight !== 5'(expTx - lastVals[i]) || CurrDelay !== currVals[i]) begin
        errors++; $display("FAIL ack_filter %0d inflight=%0d delay=%0d want %0d/%0d",
                           i, InFlight, CurrDelay, expTx - lastVals[i], currVals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    for (int f = 1; f <= 7; f++) begin
      FrameReq = 1'b1; expTx = expTx + 1; expQ.push_back(expTx);
      step();
      FrameReq = 1'b0;
      got = expQ.pop_front();
      $display("frame tx=%0d inflight=%0d", TxFrameCount, InFlight);
      checks++;
      if (TxFrameCount !== got) begin
        errors++; $display("FAIL b2b_tx got %0d want %0d", TxFrameCount, got);
      end
      FrameDone = 1'b1; step(); FrameDone = 1'b0;
      checks++;
      if (FrameGrant !== 1'b1) begin
        errors++; $display("FAIL b2b_regrant frame %0d got %b want 1", f, FrameGrant);
      end
    end
    FrameReq = 1'b1; AckValid = 1'b1; AckFrameCount = 64'd7; AckDelay = 32'd0;
    expTx = expTx + 1; expQ.push_back(expTx);
    step();
    FrameReq = 1'b0; AckValid = 1'b0;
    got = expQ.pop_front();
    $display("frame+ack tx=%0d inflight=%0d", TxFrameCount, InFlight);
    checks++;
    if (TxFrameCount !== got || InFlight !== 5'd1) begin
      errors++; $display("FAIL grant_ack_same tx=%0d inflight=%0d want %0d/1", TxFrameCount, InFlight, got);
    end
    FrameDone = 1'b1; step(); FrameDone = 1'b0;
  endtask

  task automatic test_timeout();
    int t0 = 0;
    applyReset();
    for (int f = 1; f <= 3; f++) begin
      FrameReq = 1'b1; expTx = expTx + 1; expQ.push_back(expTx);
      step();
      FrameReq = 1'b0;
      if (f == 1) t0 = cycleCount;
      got = expQ.pop_front();
      checks++;
      if (TxFrameCount !== got) begin
        errors++; $display("FAIL to_tx got %0d want %0d", TxFrameCount, got);
      end
      FrameDone = 1'b1; step(); FrameDone = 1'b0;
    end
    checks++;
    if (InFlight !== 5'd3 || AckTimeout !== 1'b0) begin
      errors++; $display("FAIL to_pre inflight=%0d timeout=%b want 3/0", InFlight, AckTimeout);
    end
    while (InFlight != 5'd0 && (cycleCount - t0) < 200) step();
    $display("resync after %0d cycles", cycleCount - t0);
    checks++;
    if ((cycleCount - t0) != 100 || AckTimeout !== 1'b1) begin
      errors++; $display("FAIL to_fire cycles=%0d timeout=%b want 100/1", cycleCount - t0, AckTimeout);
    end
    step(); step(); step();
    checks++;
    if (AckTimeout !== 1'b1 || FrameGrant !== 1'b1) begin
      errors++; $display("FAIL to_sticky timeout=%b grant=%b want 1/1", AckTimeout, FrameGrant);
    end
    FrameReq = 1'b1; expTx = expTx + 1; expQ.push_back(expTx);
    step();
    FrameReq = 1'b0;
    got = expQ.pop_front();
    checks++;
    if (TxFrameCount !== got || InFlight !== 5'd1 || AckTimeout !== 1'b1) begin
      errors++; $display("FAIL to_resume tx=%0d inflight=%0d timeout=%b want %0d/1/1", TxFrameCount, InFlight, AckTimeout, got);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wrapAck[4];
    logic [2:0] wrapInFlight[4];
    wrapAck      = '{4'd15, 4'd2, 4'd0, 4'd15};
    wrapInFlight = '{3'd2, 3'd2, 3'd1, 3'd1};
    sReset = 1'b1; sFrameReq = 1'b0; sFrameDone = 1'b0; sAckValid = 1'b0;
    sAckFrameCount = '0; sAckDelay = '0;
    step(); step();
    sReset = 1'b0; expTx = '0; expQ.delete();
    // Ack every frame as it is granted so the small window never fills.
    for (int i = 0; i < 14; i++) begin
      sFrameReq = 1'b1; sAckValid = 1'b1; sAckFrameCount = expTx[3:0];
      expTx = expTx + 1; expQ.push_back(expTx);
      step();
      sFrameReq = 1'b0; sAckValid = 1'b0;
      got = expQ.pop_front();
      checks++;
      if (sTxFrameCount !== got[3:0] || sInFlight !== 3'd1) begin
        errors++; $display("FAIL wrap_fill tx=%0d inflight=%0d want %0d/1", sTxFrameCount, sInFlight, got[3:0]);
      end
      sFrameDone = 1'b1; step(); sFrameDone = 1'b0;
    end
    sAckValid = 1'b1; sAckFrameCount = 4'd14; step(); sAckValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sFrameReq = 1'b1; step(); sFrameReq = 1'b0;
      sFrameDone = 1'b1; step(); sFrameDone = 1'b0;
    end
    checks++;
    if (sTxFrameCount !== 4'd1 || sInFlight !== 3'd3) begin
      errors++; $display("FAIL wrap_cross tx=%0d inflight=%0d want 1/3", sTxFrameCount, sInFlight);
    end
    for (int i = 0; i < 4; i++) begin
      sAckValid = 1'b1; sAckFrameCount = wrapAck[i]; sAckDelay = 32'd0;
      step();
      sAckValid = 1'b0;
      $display("wrap ack count=%0d inflight=%0d", wrapAck[i], sInFlight);
      checks++;
      if (sInFlight !== wrapInFlight[i]) begin
        errors++; $display("FAIL wrap_ack %0d inflight=%0d want %0d", i, sInFlight, wrapInFlight[i]);
      end
    end
  endtask

  task automatic test_reset_in_gap();
    applyReset();
    AckValid = 1'b1; AckFrameCount = 64'd0; AckDelay = 32'd8;
    step();
    AckValid = 1'b0;
    checks++;
    if (CurrDelay !== 32'd8) begin
      errors++; $display("FAIL gap_setup delay=%0d want 8", CurrDelay);
    end
    FrameReq = 1'b1; step(); FrameReq = 1'b0;
    FrameDone = 1'b1; step(); FrameDone = 1'b0;
    step();
    checks++;
    if (FrameGrant !== 1'b0) begin
      errors++; $display("FAIL gap_hold grant=%b want 0", FrameGrant);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (FrameGrant !== 1'b1 || CurrDelay !== 32'd0 || TxFrameCount !== 64'd0 || InFlight !== 5'd0) begin
      errors++; $display("FAIL gap_reset grant=%b delay=%0d tx=%0d inflight=%0d want 1/0/0/0",
                         FrameGrant, CurrDelay, TxFrameCount, InFlight);
    end
  endtask

  initial begin
    reset = 1'b1; FrameReq = 1'b0; FrameDone = 1'b0; AckValid = 1'b0;
    AckFrameCount = '0; AckDelay = '0;
    sReset = 1'b1; sFrameReq = 1'b0; sFrameDone = 1'b0; sAckValid = 1'b0;
    sAckFrameCount = '0; sAckDelay = '0;
    test_reset();
    test_fill_window();
    test_ack_window();
    test_ack_reject();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_reset_in_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
